// File: rtl/snes_serial_out.sv
// -----------------------------------------------------------------------------
// snes_serial_out
//
// Emulates the serial port of an SNES controller. The decoded 16-bit button
// word from the IR receive path is held for HOLD_CYCLES after the remote stops
// reporting it. The held word is shifted out LSB-first when the console pulses
// LATCH and then toggles CLOCK.
//
// Ports
//   osc_clk     in   1   system clock, all logic on its rising edge
//   reset       in   1   asynchronous, active-high reset
//   btn_in      in   16  decoded buttons, 1 = pressed, bit0 = B
//   snes_latch  in   1   console LATCH, asynchronous to osc_clk, active-high
//   snes_clk    in   1   console CLOCK, asynchronous to osc_clk, idles high
//   snes_data   out  1   serial data to console, active-low, registered
//   btn_held    out  16  currently held button word, 1 = pressed
//   frame_done  out  1   one-cycle pulse after the last bit has been shifted
// -----------------------------------------------------------------------------
module snes_serial_out #(
    parameter int HOLD_CYCLES = 240000,
    parameter int NUM_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic [15:0] btn_in,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        snes_data,
    output logic [15:0] btn_held,
    output logic        frame_done
);

    localparam int CNT_W  = $clog2(NUM_BITS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_prev;
    logic                   clk_prev;

    logic latch_s;
    logic clk_s;
    logic latch_rise;
    logic latch_fall;
    logic clk_rise;

    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       shreg;
    logic [CNT_W-1:0]  bit_cnt;

    // Console pins are synchronised, then compared against their previous
    // synchronised value. Idle levels (latch low, clock high) are the reset
    // values so that no false edge appears when reset releases.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            latch_sync <= '0;
            clk_sync   <= '1;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], snes_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
            latch_prev <= latch_s;
            clk_prev   <= clk_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev;
    assign latch_fall = ~latch_s & latch_prev;
    assign clk_rise   = clk_s & ~clk_prev;

    // Press hold: any non-zero code is captured immediately and restarts the
    // countdown; the word is dropped only once the countdown has expired.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            btn_held <= '0;
            hold_cnt <= '0;
        end else if (btn_in != '0) begin
            btn_held <= btn_in;
            hold_cnt <= HOLD_RELOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end else begin
            btn_held <= '0;
        end
    end

    // Serial frame FSM. snes_data is registered and always updated together
    // with the state it belongs to, so it follows the synchronised pins with a
    // fixed latency.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            snes_data  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    snes_data <= 1'b1;
                    if (latch_s) begin
                        state     <= LOAD;
                        shreg     <= btn_held;
                        snes_data <= ~btn_held[0];
                    end
                end

                // Reload every cycle: the value present when latch falls is
                // the snapshot the frame is shifted from.
                LOAD: begin
                    shreg     <= btn_held;
                    snes_data <= ~btn_held[0];
                    if (latch_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                // A latch edge takes priority over a clock edge in the same
                // cycle; the clock edge is simply dropped.
                SHIFT: begin
                    if (latch_rise) begin
                        state     <= LOAD;
                        shreg     <= btn_held;
                        snes_data <= ~btn_held[0];
                    end else if (clk_rise) begin
                        shreg   <= {1'b0, shreg[15:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            snes_data  <= 1'b0;
                        end else begin
                            snes_data <= ~shreg[1];
                        end
                    end
                end

                // A real controller drives 0 for clocks past the last bit.
                DONE: begin
                    snes_data <= 1'b0;
                    if (latch_s) begin
                        state     <= LOAD;
                        shreg     <= btn_held;
                        snes_data <= ~btn_held[0];
                    end
                end

                default: begin
                    state     <= IDLE;
                    snes_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_serial_out.sv
// -----------------------------------------------------------------------------
// tb_snes_serial_out
//
// Drives the block as a console would (latch 24 cycles, clock period 12
// cycles) and compares the serial stream, the held word and frame_done pulses
// against a timestamp-based model of the press-hold behaviour.
// -----------------------------------------------------------------------------
module tb_snes_serial_out;

    localparam int HOLD = 100;

    logic        osc_clk = 1'b0;
    logic        reset;
    logic [15:0] btn_in;
    logic        snes_latch;
    logic        snes_clk;
    logic        snes_data;
    logic [15:0] btn_held;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;
    bit chk_en   = 1'b0;

    // Model of the hold behaviour: the last non-zero code stays visible while
    // fewer than HOLD edges have passed since the edge that captured it.
    int unsigned cyc = 0;
    int unsigned m_t = 0;
    logic [15:0] m_code = '0;
    bit          m_valid = 1'b0;

    snes_serial_out #(
        .HOLD_CYCLES (HOLD),
        .NUM_BITS    (16),
        .SYNC_STAGES (2)
    ) dut (
        .osc_clk    (osc_clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .btn_held   (btn_held),
        .frame_done (frame_done)
    );

    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_code  <= '0;
        end else begin
            cyc <= cyc + 1;
            if (btn_in != '0) begin
                m_code  <= btn_in;
                m_t     <= cyc + 1;
                m_valid <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_held();
        return (m_valid && (cyc - m_t) < HOLD) ? m_code : 16'h0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge osc_clk) begin
        if (chk_en && !reset) check_eq("held_track", {16'h0, btn_held}, {16'h0, exp_held()});
        if (frame_done === 1'b1) fd_count++;
    end

    // Advance n cycles; inputs change 1 ns after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge osc_clk);
        #1;
    endtask

    task automatic latch_pulse(output logic [15:0] snap);
        snes_latch = 1'b1;
        step(24);
        snap = exp_held();
        snes_latch = 1'b0;
        step(6);
    endtask

    task automatic clk_bit(output logic b);
        snes_clk = 1'b0;
        step(6);
        b = snes_data;
        snes_clk = 1'b1;
        step(6);
    endtask

    task automatic shift16(output logic [15:0] word);
        logic b;
        for (int i = 0; i < 16; i++) begin
            clk_bit(b);
            word[i] = b;
        end
    endtask

    task automatic run_frame(output logic [15:0] word, output logic [15:0] snap);
        latch_pulse(snap);
        shift16(word);
    endtask

    task automatic extra_clocks(input string tag);
        logic b;
        for (int i = 0; i < 3; i++) begin
            clk_bit(b);
            check_eq(tag, {31'h0, b}, 32'h0);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] snap;
        logic [15:0] part;
        logic [15:0] rnd;
        logic        b;
        int          fd0;

        reset      = 1'b1;
        btn_in     = '0;
        snes_latch = 1'b0;
        snes_clk   = 1'b1;
        step(3);
        check_eq("rst_data",  {31'h0, snes_data},  32'h1);
        check_eq("rst_held",  {16'h0, btn_held},   32'h0);
        check_eq("rst_done",  {31'h0, frame_done}, 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step(2);

        // 1: single-cycle press of B, latch latency, full frame, extra clocks
        fd0 = fd_count;
        btn_in = 16'h0001;
        step(1);
        btn_in = 16'h0000;
        snes_latch = 1'b1;
        step(2);
        check_eq("t1_lat_2cyc", {31'h0, snes_data}, 32'h1);
        step(1);
        check_eq("t1_lat_3cyc", {31'h0, snes_data}, 32'h0);
        step(21);
        snes_latch = 1'b0;
        step(6);
        shift16(w);
        check_eq("t1_word", {16'h0, w}, 32'h0000FFFE);
        check_eq("t1_tail", {31'h0, snes_data}, 32'h0);
        extra_clocks("t1_extra");
        check_eq("t1_fd", fd_count - fd0, 1);

        // 2: press released before the frame, hold expires mid-frame
        fd0 = fd_count;
        btn_in = 16'h0A05;
        step(1);
        btn_in = 16'h0000;
        step(50);
        run_frame(w, snap);
        check_eq("t2_word", {16'h0, w}, {16'h0, ~16'h0A05});
        check_eq("t2_tail", {31'h0, snes_data}, 32'h0);
        check_eq("t2_fd", fd_count - fd0, 1);

        // 3: new code overwrites held word and restarts the hold
        btn_in = 16'h0010;
        step(1);
        btn_in = 16'h0000;
        step(40);
        btn_in = 16'h0800;
        step(1);
        check_eq("t3_overwrite", {16'h0, btn_held}, 32'h0800);
        btn_in = 16'h0000;
        step(99);
        check_eq("t3_hold_last", {16'h0, btn_held}, 32'h0800);
        step(1);
        check_eq("t3_hold_clr", {16'h0, btn_held}, 32'h0);

        // 4: latch re-asserted after the 7th clock edge aborts the frame
        fd0 = fd_count;
        btn_in = 16'h5A3C;
        latch_pulse(snap);
        part = '0;
        for (int i = 0; i < 7; i++) begin
            clk_bit(b);
            part[i] = b;
        end
        check_eq("t4_partial", {16'h0, part}, {16'h0, (~16'h5A3C) & 16'h007F});
        run_frame(w, snap);
        check_eq("t4_word", {16'h0, w}, {16'h0, ~16'h5A3C});
        check_eq("t4_fd", fd_count - fd0, 1);
        btn_in = 16'h0000;
        step(5);

        // 5: reset after the 5th clock edge
        fd0 = fd_count;
        btn_in = 16'h00F0;
        latch_pulse(snap);
        part = '0;
        for (int i = 0; i < 5; i++) begin
            clk_bit(b);
            part[i] = b;
        end
        check_eq("t5_partial", {16'h0, part}, {16'h0, (~16'h00F0) & 16'h001F});
        check_eq("t5_pre_rst", {31'h0, snes_data}, 32'h0);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_data", {31'h0, snes_data}, 32'h1);
        check_eq("t5_rst_held", {16'h0, btn_held},  32'h0);
        btn_in = 16'h0000;
        step(2);
        reset = 1'b0;
        step(3);
        run_frame(w, snap);
        check_eq("t5_word", {16'h0, w}, 32'h0000FFFF);
        check_eq("t5_fd", fd_count - fd0, 1);

        // 6: latch fall and clock rise arrive in the same cycle
        fd0 = fd_count;
        btn_in = 16'hC3A6;
        snes_latch = 1'b1;
        step(12);
        snes_clk = 1'b0;
        step(12);
        snes_latch = 1'b0;
        snes_clk   = 1'b1;
        step(6);
        check_eq("t6_bit0_held", {31'h0, snes_data}, 32'h1);
        shift16(w);
        check_eq("t6_word", {16'h0, w}, {16'h0, ~16'hC3A6});
        check_eq("t6_tail", {31'h0, snes_data}, 32'h0);
        check_eq("t6_fd", fd_count - fd0, 1);
        btn_in = 16'h0000;
        step(5);

        // Randomised presses and frames against the model
        for (int k = 0; k < 8; k++) begin
            fd0 = fd_count;
            if (k % 4 == 3) begin
                step(HOLD + $urandom_range(1, 20));
            end else begin
                rnd = 16'($urandom_range(1, 16'hFFFF));
                btn_in = rnd;
                step($urandom_range(1, 3));
                btn_in = 16'h0000;
                step($urandom_range(1, 20));
            end
            run_frame(w, snap);
            check_eq("rnd_word", {16'h0, w}, {16'h0, ~snap});
            check_eq("rnd_tail", {31'h0, snes_data}, 32'h0);
            if (k % 2 == 0) extra_clocks("rnd_extra");
            check_eq("rnd_fd", fd_count - fd0, 1);
        end

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
